// File: rtl/col_ctrl_pkg.sv
// Shared definitions for the ReRAM column/row driver sequencers:
// operation codes, sequencer state encoding and default phase lengths.
package col_ctrl_pkg;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_SET     = 2'b01;
    localparam logic [1:0] OP_RESET   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int PRE_CYC_DEF  = 4;
    localparam int DEAD_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DEAD1 = 3'd2,
        ST_PULSE = 3'd3,
        ST_DEAD2 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; `last` is high while the count sits at 1, which marks
// the final cycle of the phase that was just loaded.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > W'(1)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/col_pulse_sequencer.sv
// Column-driver switch sequencer: precharge, dead time, pulse, dead time, done.
// Switch enables decode from the registered state only, so at most one is ever on.
module col_pulse_sequencer
    import col_ctrl_pkg::*;
#(
    parameter int PRE_CYC  = PRE_CYC_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int PW_W     = 8
) (
`ifdef USE_POWER_PINS
    inout  wire             vccd1,
    inout  wire             vssd1,
`endif
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [PW_W-1:0] pulse_w,
    input  logic            abort,
    output logic            SWref,
    output logic            SWc_plus,
    output logic            SWc_minus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            aborted,
    output logic [2:0]      dbg_state
);

    localparam int CW = max3(PW_W, $clog2(PRE_CYC + 1), $clog2(DEAD_CYC + 1));
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYC);
    localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC);

    // Request handshake: start is a level sampled on each edge while IDLE.
    // A legal request (op != 11, pulse_w != 0) is accepted on that edge and
    // op/pulse_w are captured; an illegal one yields a one-cycle err pulse.
    // While busy, start is ignored. abort acts only in PRE, DEAD1 and PULSE.
    state_t          state, next_state;
    logic [1:0]      op_q;
    logic [PW_W-1:0] pw_q;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_last;
    logic            req_ok;
    logic            abortable;

    assign req_ok    = (op != OP_ILLEGAL) && (pulse_w != '0);
    assign abortable = (state == ST_PRE) || (state == ST_DEAD1) || (state == ST_PULSE);

    phase_timer #(.W(CW)) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = CW'(1);
        case (state)
            ST_IDLE:  if (start && req_ok) next_state = ST_PRE;
            ST_PRE:   if (abort) next_state = ST_DEAD2;
                      else if (tmr_last) next_state = ST_DEAD1;
            ST_DEAD1: if (abort) next_state = ST_DEAD2;
                      else if (tmr_last) next_state = ST_PULSE;
            ST_PULSE: if (abort || tmr_last) next_state = ST_DEAD2;
            ST_DEAD2: if (tmr_last) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        // Every phase entry reloads the shared counter with that phase's length.
        if (next_state != state) begin
            tmr_load = 1'b1;
            case (next_state)
                ST_PRE:   tmr_val = PRE_LD;
                ST_DEAD1: tmr_val = DEAD_LD;
                ST_DEAD2: tmr_val = DEAD_LD;
                ST_PULSE: tmr_val = CW'(pw_q);
                default:  tmr_val = CW'(1);
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            op_q    <= OP_READ;
            pw_q    <= '0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else begin
            err <= (state == ST_IDLE) && start && !req_ok;
            if ((state == ST_IDLE) && start && req_ok) begin
                op_q    <= op;
                pw_q    <= pulse_w;
                aborted <= 1'b0;
            end else if (abort && abortable) begin
                aborted <= 1'b1;
            end
        end
    end

    assign SWref     = (state == ST_PRE) || ((state == ST_PULSE) && (op_q == OP_READ));
    assign SWc_plus  = (state == ST_PULSE) && (op_q == OP_SET);
    assign SWc_minus = (state == ST_PULSE) && (op_q == OP_RESET);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_col_pulse_sequencer.sv
// Bench for col_pulse_sequencer: a per-cycle schedule model checked every cycle,
// directed scenarios with literal expectations, and randomized operations.
module tb_col_pulse_sequencer;

    localparam int PRE  = 4;
    localparam int DEAD = 2;
    localparam int PW_W = 8;

    localparam logic [2:0] P_IDLE = 3'd0, P_PRE = 3'd1, P_D1 = 3'd2,
                           P_PULSE = 3'd3, P_D2 = 3'd4, P_DONE = 3'd5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [PW_W-1:0] pulse_w = '0;
    logic            abort = 1'b0;
    logic            SWref, SWc_plus, SWc_minus, busy, done, err, aborted;
    logic [2:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected-schedule queue: each entry is {phase, busy, done, ref, plus, minus}.
    logic [7:0] exp_q[$];
    logic [7:0] cur = {P_IDLE, 5'b00000};
    logic       m_err = 1'b0;
    logic       m_ab = 1'b0;

    col_pulse_sequencer #(.PRE_CYC(PRE), .DEAD_CYC(DEAD), .PW_W(PW_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .start     (start),
        .op        (op),
        .pulse_w   (pulse_w),
        .abort     (abort),
        .SWref     (SWref),
        .SWc_plus  (SWc_plus),
        .SWc_minus (SWc_minus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_sched(input logic [1:0] o, input int p);
        for (int i = 0; i < PRE; i++)  exp_q.push_back({P_PRE, 5'b10100});
        for (int i = 0; i < DEAD; i++) exp_q.push_back({P_D1, 5'b10000});
        for (int i = 0; i < p; i++) begin
            if (o == 2'b00)      exp_q.push_back({P_PULSE, 5'b10100});
            else if (o == 2'b01) exp_q.push_back({P_PULSE, 5'b10010});
            else                 exp_q.push_back({P_PULSE, 5'b10001});
        end
        for (int i = 0; i < DEAD; i++) exp_q.push_back({P_D2, 5'b10000});
        exp_q.push_back({P_DONE, 5'b11000});
    endtask

    // model update on each edge, then compare 1 time unit later
    always begin
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            cur   = {P_IDLE, 5'b00000};
            m_err = 1'b0;
            m_ab  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (cur[7:5] == P_IDLE) begin
                if (start) begin
                    if (op != 2'b11 && pulse_w != 0) begin
                        push_sched(op, int'(pulse_w));
                        m_ab = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (abort && (cur[7:5] == P_PRE || cur[7:5] == P_D1 || cur[7:5] == P_PULSE)) begin
                exp_q.delete();
                for (int i = 0; i < DEAD; i++) exp_q.push_back({P_D2, 5'b10000});
                exp_q.push_back({P_DONE, 5'b11000});
                m_ab = 1'b1;
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : {P_IDLE, 5'b00000};
        end
        #1;
        chk("busy", busy, cur[4]);
        chk("done", done, cur[3]);
        chk("SWref", SWref, cur[2]);
        chk("SWc_plus", SWc_plus, cur[1]);
        chk("SWc_minus", SWc_minus, cur[0]);
        chk("err", err, m_err);
        chk("aborted", aborted, m_ab);
        chk("one_hot", 32'(SWref) + 32'(SWc_plus) + 32'(SWc_minus) <= 1, 1);
    end

    // driver tasks
    task automatic do_start(input logic [1:0] o, input int p);
        start   = 1'b1;
        op      = o;
        pulse_w = PW_W'(p);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_until_idle(output int nb, output int nr, output int np,
                                  output int nm, output int nd);
        nb = 0; nr = 0; np = 0; nm = 0; nd = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            nb++;
            nr += int'(SWref);
            np += int'(SWc_plus);
            nm += int'(SWc_minus);
            nd += int'(done);
            @(negedge clk);
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_plus();
        for (int i = 0; i < 100 && !SWc_plus; i++) @(negedge clk);
        chk("plus_timeout", SWc_plus, 1);
    endtask

    initial begin
        int nb, nr, np, nm, nd;

        repeat (3) @(negedge clk);
        chk("rst_switches", {SWref, SWc_plus, SWc_minus}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, err, aborted}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // SET, pulse_w=5
        do_start(2'b01, 5);
        chk("set_first_ref", SWref, 1);
        run_until_idle(nb, nr, np, nm, nd);
        chk("set_busy_len", nb, 14);
        chk("set_ref_len", nr, 4);
        chk("set_plus_len", np, 5);
        chk("set_minus_len", nm, 0);
        chk("set_done_cnt", nd, 1);

        // RESET, pulse_w=1
        do_start(2'b10, 1);
        run_until_idle(nb, nr, np, nm, nd);
        chk("rst1_busy_len", nb, 10);
        chk("rst1_minus_len", nm, 1);
        chk("rst1_plus_len", np, 0);

        // rejected requests
        do_start(2'b11, 5);
        chk("ill_op_err", err, 1);
        chk("ill_op_busy", busy, 0);
        do_start(2'b01, 0);
        chk("zero_pw_err", err, 1);
        chk("zero_pw_sw", {SWref, SWc_plus, SWc_minus}, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);

        // SET pw=200, abort in 10th pulse cycle
        do_start(2'b01, 200);
        wait_plus();
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_plus_off", SWc_plus, 0);
        chk("abort_flag", aborted, 1);
        run_until_idle(nb, nr, np, nm, nd);
        chk("abort_tail_len", nb, 3);
        chk("abort_done", nd, 1);
        chk("abort_sticky", aborted, 1);
        do_start(2'b00, 3);
        chk("abort_cleared", aborted, 0);
        run_until_idle(nb, nr, np, nm, nd);

        // repeated start while busy
        do_start(2'b00, 4);
        nb = 1;
        for (int i = 0; i < 100 && busy; i++) begin
            start   = 1'($urandom_range(0, 1));
            op      = 2'($urandom_range(0, 3));
            pulse_w = PW_W'($urandom_range(1, 9));
            @(negedge clk);
            if (busy) nb++;
        end
        start = 1'b0;
        chk("busy_start_len", nb, 13);

        // start coincident with abort in IDLE
        start = 1'b1; abort = 1'b1; op = 2'b01; pulse_w = 3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("coinc_busy", busy, 1);
        chk("coinc_ref", SWref, 1);
        run_until_idle(nb, nr, np, nm, nd);
        chk("coinc_len", nb, 12);
        chk("coinc_plus", np, 3);
        chk("coinc_not_aborted", aborted, 0);

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            do_start(2'($urandom_range(0, 3)), $urandom_range(0, 12));
            for (int i = 0; i < 200 && busy; i++) begin
                abort   = ($urandom_range(0, 15) == 0);
                start   = 1'($urandom_range(0, 1));
                op      = 2'($urandom_range(0, 3));
                pulse_w = PW_W'($urandom_range(0, 12));
                @(negedge clk);
            end
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            @(negedge clk);
            abort = 1'b0;
            chk("rand_idle", busy, 0);
        end

        // reset mid-PULSE
        do_start(2'b01, 30);
        wait_plus();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_switches", {SWref, SWc_plus, SWc_minus}, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", dbg_state, 0);
        do_start(2'b00, 2);
        run_until_idle(nb, nr, np, nm, nd);
        chk("post_rst_len", nb, 11);
        chk("post_rst_ref", nr, 6);
        chk("post_rst_done", nd, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
